// File: rtl/ifu_bpu_jalr_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifu_bpu_jalr_seq                                              |
// | Purpose  : jalr target-operand sequencer for the IFU lite branch         |
// |            predictor. Classifies a decoded jalr by rs1 (x0 / x1 / xN),   |
// |            stalls fetch while a register dependency is outstanding,      |
// |            arbitrates regfile read port 1 against the EXU and emits      |
// |            rs1/imm as next-PC adder operands with a one-cycle pulse.     |
// | Ports    : clk, rst (async, active-high)                                 |
// |            jalr_req_valid/jalr_rs1idx/jalr_imm : decoded jalr request    |
// |            flush                               : cancel in-flight jalr   |
// |            oitf_empty, ir_valid/ir_rdwen/ir_rdidx : hazard sources       |
// |            exu_rs1_req/exu_rs1_gnt             : EXU port-1 handshake    |
// |            rf_rs1_sel/rf_rs1_idx/rf2bpu_rs1    : BPU port-1 read         |
// |            rf2bpu_x1                           : dedicated x1 value      |
// |            bpu_wait, prdt_valid, prdt_pc_add_op1/op2 : results           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ifu_bpu_jalr_seq #(
  parameter int X_LEN       = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int STARVE_MAX  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jalr_req_valid,
  input  logic [RFIDX_WIDTH-1:0] jalr_rs1idx,
  input  logic [X_LEN-1:0]       jalr_imm,
  input  logic                   flush,
  input  logic                   oitf_empty,
  input  logic                   ir_valid,
  input  logic                   ir_rdwen,
  input  logic [RFIDX_WIDTH-1:0] ir_rdidx,
  input  logic                   exu_rs1_req,
  output logic                   exu_rs1_gnt,
  output logic                   rf_rs1_sel,
  output logic [RFIDX_WIDTH-1:0] rf_rs1_idx,
  input  logic [X_LEN-1:0]       rf2bpu_x1,
  input  logic [X_LEN-1:0]       rf2bpu_rs1,
  output logic                   bpu_wait,
  output logic                   prdt_valid,
  output logic [X_LEN-1:0]       prdt_pc_add_op1,
  output logic [X_LEN-1:0]       prdt_pc_add_op2
);

  // STARVE_MAX is limited to 1..7, so three bits always suffice.
  localparam int              c_cnt_w       = 3;
  localparam logic [c_cnt_w-1:0] c_starve_lim = c_cnt_w'(STARVE_MAX);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_X1 = 3'd1,
    S_WAIT_XN = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [RFIDX_WIDTH-1:0]   r_rs1idx;
  logic [X_LEN-1:0]         r_imm;
  logic [X_LEN-1:0]         r_op1;
  logic [X_LEN-1:0]         r_op2;
  logic [c_cnt_w-1:0]       r_starve_cnt;
  logic [c_cnt_w-1:0]       w_starve_next;

  logic                     w_x1_dep;
  logic                     w_xn_dep;
  logic                     w_cancel;
  logic                     w_rs1_x0;
  logic                     w_rs1_x1;
  logic                     w_grant_ok;
  logic                     w_prdt;
  logic                     w_wait;
  logic                     w_sel;
  logic                     w_latch;
  logic [X_LEN-1:0]         w_op1_new;
  logic [X_LEN-1:0]         w_op2_new;

  always_comb begin
    w_x1_dep   = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == RFIDX_WIDTH'(1)));
    w_xn_dep   = ~oitf_empty | ir_valid;
    // A request that disappears while being worked on is treated like a flush.
    w_cancel   = flush | ((r_state != S_IDLE) & ~jalr_req_valid);
    w_rs1_x0   = (jalr_rs1idx == '0);
    w_rs1_x1   = (jalr_rs1idx == RFIDX_WIDTH'(1));
    w_grant_ok = ~exu_rs1_req | (r_starve_cnt == c_starve_lim);
  end

  always_comb begin
    w_next_state  = r_state;
    w_starve_next = r_starve_cnt;
    w_prdt        = 1'b0;
    w_wait        = 1'b0;
    w_sel         = 1'b0;
    w_latch       = 1'b0;
    w_op1_new     = '0;
    w_op2_new     = r_imm;

    if (w_cancel) begin
      w_next_state  = S_IDLE;
      w_starve_next = '0;
      w_wait        = (r_state != S_IDLE);
    end else begin
      case (r_state)
        S_IDLE: begin
          w_op2_new = jalr_imm;
          if (jalr_req_valid) begin
            if (w_rs1_x0) begin
              w_prdt = 1'b1;
            end else if (w_rs1_x1 && !w_x1_dep) begin
              w_prdt    = 1'b1;
              w_op1_new = rf2bpu_x1;
            end else begin
              w_wait  = 1'b1;
              w_latch = 1'b1;
              if (w_rs1_x1)      w_next_state = S_WAIT_X1;
              else if (w_xn_dep) w_next_state = S_WAIT_XN;
              else               w_next_state = S_RD_REQ;
            end
          end
        end
        S_WAIT_X1: begin
          if (w_x1_dep) begin
            w_wait = 1'b1;
          end else begin
            w_prdt       = 1'b1;
            w_op1_new    = rf2bpu_x1;
            w_next_state = S_IDLE;
          end
        end
        S_WAIT_XN: begin
          w_wait = 1'b1;
          if (!w_xn_dep) w_next_state = S_RD_REQ;
        end
        S_RD_REQ: begin
          w_wait = 1'b1;
          if (w_grant_ok) begin
            w_sel         = 1'b1;
            w_starve_next = '0;
            w_next_state  = S_RD_DATA;
          end else begin
            // A denial only happens below the limit, so this never overflows
            // past STARVE_MAX: reaching the limit forces the grant instead.
            w_starve_next = r_starve_cnt + c_cnt_w'(1);
          end
        end
        S_RD_DATA: begin
          w_prdt       = 1'b1;
          w_op1_new    = rf2bpu_rs1;
          w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_rs1idx     <= '0;
      r_imm        <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
    end else begin
      r_state      <= w_next_state;
      r_starve_cnt <= w_starve_next;
      if (w_latch) begin
        r_rs1idx <= jalr_rs1idx;
        r_imm    <= jalr_imm;
      end
      if (w_prdt) begin
        r_op1 <= w_op1_new;
        r_op2 <= w_op2_new;
      end
    end
  end

  // Operands show fresh values on the pulse and hold them afterwards.
  assign prdt_valid      = w_prdt;
  assign prdt_pc_add_op1 = w_prdt ? w_op1_new : r_op1;
  assign prdt_pc_add_op2 = w_prdt ? w_op2_new : r_op2;
  assign bpu_wait        = w_wait;
  assign rf_rs1_sel      = w_sel;
  assign rf_rs1_idx      = w_sel ? r_rs1idx : '0;
  assign exu_rs1_gnt     = exu_rs1_req & ~w_sel;

endmodule
`default_nettype wire

// File: tb/tb_ifu_bpu_jalr_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ifu_bpu_jalr_seq                                           |
// | Purpose  : self-checking bench for ifu_bpu_jalr_seq: vector table of     |
// |            single-cycle IDLE decisions, directed multi-cycle sequences   |
// |            and randomized traffic against a request-level model.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ifu_bpu_jalr_seq;
  localparam int XL = 32;
  localparam int RW = 5;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          jalr_req_valid;
  logic [RW-1:0] jalr_rs1idx;
  logic [XL-1:0] jalr_imm;
  logic          flush;
  logic          oitf_empty;
  logic          ir_valid;
  logic          ir_rdwen;
  logic [RW-1:0] ir_rdidx;
  logic          exu_rs1_req;
  logic          exu_rs1_gnt;
  logic          rf_rs1_sel;
  logic [RW-1:0] rf_rs1_idx;
  logic [XL-1:0] rf2bpu_x1;
  logic [XL-1:0] rf2bpu_rs1;
  logic          bpu_wait;
  logic          prdt_valid;
  logic [XL-1:0] prdt_pc_add_op1;
  logic [XL-1:0] prdt_pc_add_op2;

  always #5 clk = ~clk;

  ifu_bpu_jalr_seq #(.X_LEN(XL), .RFIDX_WIDTH(RW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .jalr_req_valid(jalr_req_valid), .jalr_rs1idx(jalr_rs1idx), .jalr_imm(jalr_imm),
    .flush(flush), .oitf_empty(oitf_empty), .ir_valid(ir_valid), .ir_rdwen(ir_rdwen),
    .ir_rdidx(ir_rdidx), .exu_rs1_req(exu_rs1_req), .exu_rs1_gnt(exu_rs1_gnt),
    .rf_rs1_sel(rf_rs1_sel), .rf_rs1_idx(rf_rs1_idx), .rf2bpu_x1(rf2bpu_x1),
    .rf2bpu_rs1(rf2bpu_rs1), .bpu_wait(bpu_wait), .prdt_valid(prdt_valid),
    .prdt_pc_add_op1(prdt_pc_add_op1), .prdt_pc_add_op2(prdt_pc_add_op2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet_inputs;
    jalr_req_valid = 1'b0; jalr_rs1idx = '0; jalr_imm = '0; flush = 1'b0;
    oitf_empty = 1'b1; ir_valid = 1'b0; ir_rdwen = 1'b0; ir_rdidx = '0;
    exu_rs1_req = 1'b0; rf2bpu_x1 = '0; rf2bpu_rs1 = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          req;
    logic [RW-1:0] rs1;
    logic [XL-1:0] imm;
    logic          fl, oe, irv, irw;
    logic [RW-1:0] ird;
    logic          exu;
    logic [XL-1:0] x1;
    logic          e_prdt, e_wait, e_gnt;
    logic [XL-1:0] e_op1, e_op2;
  } vec_t;

  function automatic vec_t mkv(input logic req, input logic [RW-1:0] rs1, input logic [XL-1:0] imm,
                               input logic fl, input logic oe, input logic irv, input logic irw,
                               input logic [RW-1:0] ird, input logic exu, input logic [XL-1:0] x1,
                               input logic ep, input logic ew, input logic eg,
                               input logic [XL-1:0] eo1, input logic [XL-1:0] eo2);
    vec_t v;
    v.req = req; v.rs1 = rs1; v.imm = imm; v.fl = fl; v.oe = oe; v.irv = irv; v.irw = irw;
    v.ird = ird; v.exu = exu; v.x1 = x1; v.e_prdt = ep; v.e_wait = ew; v.e_gnt = eg;
    v.e_op1 = eo1; v.e_op2 = eo2;
    return v;
  endfunction

  localparam int NV = 14;
  vec_t vt [NV];

  // ---------------- request-level reference model ----------------
  // The model tracks what is still owed for the outstanding jalr rather than
  // any particular state encoding.
  bit            m_pending, m_need_x1, m_need_xn, m_need_port, m_data_due;
  int            m_denials;
  logic [RW-1:0] m_rs1;
  logic [XL-1:0] m_imm, m_last1, m_last2;
  logic          e_prdt, e_wait, e_gnt, e_sel;
  logic [RW-1:0] e_idx;
  logic [XL-1:0] e_op1, e_op2;

  task automatic model_reset;
    m_pending = 0; m_need_x1 = 0; m_need_xn = 0; m_need_port = 0; m_data_due = 0;
    m_denials = 0; m_rs1 = '0; m_imm = '0; m_last1 = '0; m_last2 = '0;
  endtask

  task automatic model_step;
    bit            x1dep, xndep, fire;
    logic [XL-1:0] o1, o2;
    x1dep = !oitf_empty || (ir_valid && ir_rdwen && ir_rdidx == 5'd1);
    xndep = !oitf_empty || ir_valid;
    fire = 0; o1 = '0; o2 = m_imm; e_wait = 0; e_sel = 0; e_idx = '0;
    if (m_pending && (flush || !jalr_req_valid)) begin
      e_wait = 1; m_pending = 0; m_denials = 0;
      m_need_x1 = 0; m_need_xn = 0; m_need_port = 0; m_data_due = 0;
    end else if (!m_pending) begin
      if (jalr_req_valid && !flush) begin
        o2 = jalr_imm;
        if (jalr_rs1idx == 0) begin
          fire = 1;
        end else if (jalr_rs1idx == 1 && !x1dep) begin
          fire = 1; o1 = rf2bpu_x1;
        end else begin
          e_wait = 1; m_pending = 1; m_rs1 = jalr_rs1idx; m_imm = jalr_imm;
          m_need_x1   = (jalr_rs1idx == 1);
          m_need_xn   = (jalr_rs1idx != 1) && xndep;
          m_need_port = (jalr_rs1idx != 1) && !xndep;
        end
      end
    end else if (m_need_x1) begin
      if (x1dep) e_wait = 1;
      else begin fire = 1; o1 = rf2bpu_x1; m_need_x1 = 0; m_pending = 0; end
    end else if (m_need_xn) begin
      e_wait = 1;
      if (!xndep) begin m_need_xn = 0; m_need_port = 1; end
    end else if (m_need_port) begin
      e_wait = 1;
      if (!exu_rs1_req || m_denials >= SM) begin
        e_sel = 1; e_idx = m_rs1; m_denials = 0; m_need_port = 0; m_data_due = 1;
      end else begin
        m_denials = m_denials + 1;
      end
    end else begin
      fire = 1; o1 = rf2bpu_rs1; m_data_due = 0; m_pending = 0;
    end
    e_prdt = fire;
    e_gnt  = exu_rs1_req && !e_sel;
    if (fire) begin m_last1 = o1; m_last2 = o2; end
    e_op1 = m_last1; e_op2 = m_last2;
  endtask

  initial begin
    quiet_inputs();
    rst = 1'b1;
    vt[0]  = mkv(1, 0,  32'h10,       0, 1, 0, 0, 0, 0, 0,          1, 0, 0, 32'h0,    32'h10);
    vt[1]  = mkv(1, 0,  32'h10,       1, 1, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0);
    vt[2]  = mkv(1, 1,  32'h4,        0, 1, 0, 0, 0, 0, 32'h8000,   1, 0, 0, 32'h8000, 32'h4);
    vt[3]  = mkv(1, 1,  32'h8,        0, 1, 1, 1, 2, 0, 32'habcd,   1, 0, 0, 32'habcd, 32'h8);
    vt[4]  = mkv(1, 1,  32'h8,        0, 0, 0, 0, 0, 0, 32'h1,      0, 1, 0, 0, 0);
    vt[5]  = mkv(1, 1,  32'h8,        0, 1, 1, 1, 1, 0, 32'h1,      0, 1, 0, 0, 0);
    vt[6]  = mkv(1, 1,  32'hc,        0, 1, 1, 0, 1, 0, 32'h55,     1, 0, 0, 32'h55,   32'hc);
    vt[7]  = mkv(1, 1,  32'hc,        1, 1, 1, 1, 1, 0, 32'h55,     0, 0, 0, 0, 0);
    vt[8]  = mkv(1, 5,  32'h40,       0, 1, 0, 0, 0, 0, 0,          0, 1, 0, 0, 0);
    vt[9]  = mkv(1, 5,  32'h40,       0, 1, 1, 0, 0, 0, 0,          0, 1, 0, 0, 0);
    vt[10] = mkv(1, 9,  32'h40,       0, 0, 0, 0, 0, 1, 0,          0, 1, 1, 0, 0);
    vt[11] = mkv(0, 0,  32'h0,        0, 1, 0, 0, 0, 1, 0,          0, 0, 1, 0, 0);
    vt[12] = mkv(1, 7,  32'h40,       1, 1, 0, 0, 0, 1, 0,          0, 0, 1, 0, 0);
    vt[13] = mkv(1, 31, 32'hfffffff0, 0, 1, 0, 0, 0, 0, 0,          0, 1, 0, 0, 0);

    // ---- reset state ----
    @(negedge clk); @(negedge clk);
    chk("reset prdt_valid", 32'(prdt_valid), 0);
    chk("reset bpu_wait",   32'(bpu_wait), 0);
    chk("reset rf_rs1_sel", 32'(rf_rs1_sel), 0);
    chk("reset rf_rs1_idx", 32'(rf_rs1_idx), 0);
    chk("reset op1", prdt_pc_add_op1, 0);
    chk("reset op2", prdt_pc_add_op2, 0);
    rst = 1'b0;
    tick();

    // ---- table: decisions taken from IDLE ----
    for (int i = 0; i < NV; i++) begin
      jalr_req_valid = vt[i].req; jalr_rs1idx = vt[i].rs1; jalr_imm = vt[i].imm;
      flush = vt[i].fl; oitf_empty = vt[i].oe; ir_valid = vt[i].irv; ir_rdwen = vt[i].irw;
      ir_rdidx = vt[i].ird; exu_rs1_req = vt[i].exu; rf2bpu_x1 = vt[i].x1;
      #1;
      chk($sformatf("vec%0d prdt_valid", i), 32'(prdt_valid), 32'(vt[i].e_prdt));
      chk($sformatf("vec%0d bpu_wait", i), 32'(bpu_wait), 32'(vt[i].e_wait));
      chk($sformatf("vec%0d exu_rs1_gnt", i), 32'(exu_rs1_gnt), 32'(vt[i].e_gnt));
      chk($sformatf("vec%0d rf_rs1_sel", i), 32'(rf_rs1_sel), 0);
      if (vt[i].e_prdt) begin
        chk($sformatf("vec%0d op1", i), prdt_pc_add_op1, vt[i].e_op1);
        chk($sformatf("vec%0d op2", i), prdt_pc_add_op2, vt[i].e_op2);
      end
      tick();
      quiet_inputs();
      tick();
    end

    // ---- x1 with a 3-cycle rd dependency ----
    jalr_req_valid = 1; jalr_rs1idx = 1; jalr_imm = 32'h20;
    ir_valid = 1; ir_rdwen = 1; ir_rdidx = 1; rf2bpu_x1 = 32'h8000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("x1dep c%0d bpu_wait", c), 32'(bpu_wait), 1);
      chk($sformatf("x1dep c%0d prdt_valid", c), 32'(prdt_valid), 0);
      tick();
    end
    ir_rdwen = 0;
    #1;
    chk("x1dep prdt_valid", 32'(prdt_valid), 1);
    chk("x1dep bpu_wait", 32'(bpu_wait), 0);
    chk("x1dep op1", prdt_pc_add_op1, 32'h8000);
    chk("x1dep op2", prdt_pc_add_op2, 32'h20);
    tick(); quiet_inputs(); #1;
    chk("x1dep hold op1", prdt_pc_add_op1, 32'h8000);
    tick();

    // ---- x5, no contention: 2-cycle latency ----
    jalr_req_valid = 1; jalr_rs1idx = 5; jalr_imm = 32'h40;
    #1; chk("x5 c0 bpu_wait", 32'(bpu_wait), 1);
    tick(); #1;
    chk("x5 c1 rf_rs1_sel", 32'(rf_rs1_sel), 1);
    chk("x5 c1 rf_rs1_idx", 32'(rf_rs1_idx), 5);
    tick(); rf2bpu_rs1 = 32'h1234; #1;
    chk("x5 c2 rf_rs1_sel", 32'(rf_rs1_sel), 0);
    chk("x5 c2 prdt_valid", 32'(prdt_valid), 1);
    chk("x5 c2 op1", prdt_pc_add_op1, 32'h1234);
    chk("x5 c2 op2", prdt_pc_add_op2, 32'h40);
    tick(); quiet_inputs(); tick();

    // ---- x5 under EXU contention: starvation limit ----
    jalr_req_valid = 1; jalr_rs1idx = 5; jalr_imm = 32'h44; exu_rs1_req = 1;
    tick();
    for (int c = 0; c < SM; c++) begin
      #1;
      chk($sformatf("starve d%0d exu_rs1_gnt", c), 32'(exu_rs1_gnt), 1);
      chk($sformatf("starve d%0d rf_rs1_sel", c), 32'(rf_rs1_sel), 0);
      tick();
    end
    #1;
    chk("starve grant exu_rs1_gnt", 32'(exu_rs1_gnt), 0);
    chk("starve grant rf_rs1_idx", 32'(rf_rs1_idx), 5);
    tick(); rf2bpu_rs1 = 32'h77; #1;
    chk("starve data prdt_valid", 32'(prdt_valid), 1);
    chk("starve data op1", prdt_pc_add_op1, 32'h77);
    tick(); quiet_inputs(); tick();

    // ---- flush in RD_DATA ----
    jalr_req_valid = 1; jalr_rs1idx = 6; jalr_imm = 32'h48; rf2bpu_rs1 = 32'h99;
    tick(); tick(); flush = 1; #1;
    chk("flush rd_data prdt_valid", 32'(prdt_valid), 0);
    chk("flush op1 held", prdt_pc_add_op1, 32'h77);
    tick(); quiet_inputs(); #1;
    chk("flush after bpu_wait", 32'(bpu_wait), 0);
    chk("flush after prdt_valid", 32'(prdt_valid), 0);
    chk("flush after rf_rs1_sel", 32'(rf_rs1_sel), 0);
    tick();

    // ---- reset while in WAIT_XN ----
    jalr_req_valid = 1; jalr_rs1idx = 9; jalr_imm = 32'h50; ir_valid = 1;
    tick(); #1;
    chk("wait_xn bpu_wait", 32'(bpu_wait), 1);
    @(negedge clk);
    quiet_inputs(); rst = 1; #1;
    chk("rst mid bpu_wait", 32'(bpu_wait), 0);
    chk("rst mid prdt_valid", 32'(prdt_valid), 0);
    chk("rst mid op1", prdt_pc_add_op1, 0);
    chk("rst mid op2", prdt_pc_add_op2, 0);
    tick(); rst = 0; tick();
    jalr_req_valid = 1; jalr_rs1idx = 0; jalr_imm = 32'h10; #1;
    chk("post rst x0 prdt_valid", 32'(prdt_valid), 1);
    chk("post rst x0 op2", prdt_pc_add_op2, 32'h10);
    tick(); quiet_inputs(); tick();

    // ---- randomized traffic against the model ----
    rst = 1; #1; rst = 0;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1; #2; rst = 0;
        model_reset();
      end
      if (m_pending) begin
        jalr_req_valid = ($urandom_range(0, 19) != 0);
      end else begin
        jalr_req_valid = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 3))
          0:       jalr_rs1idx = 5'd0;
          1:       jalr_rs1idx = 5'd1;
          default: jalr_rs1idx = 5'($urandom_range(2, 31));
        endcase
        jalr_imm = $urandom;
      end
      flush       = ($urandom_range(0, 29) == 0);
      oitf_empty  = ($urandom_range(0, 3) != 0);
      ir_valid    = ($urandom_range(0, 2) == 0);
      ir_rdwen    = 1'($urandom_range(0, 1));
      ir_rdidx    = ($urandom_range(0, 1) == 1) ? 5'd1 : 5'($urandom_range(0, 31));
      exu_rs1_req = ($urandom_range(0, 9) < 7);
      rf2bpu_x1   = $urandom;
      rf2bpu_rs1  = $urandom;
      #1;
      model_step();
      chk("rnd prdt_valid",  32'(prdt_valid),  32'(e_prdt));
      chk("rnd bpu_wait",    32'(bpu_wait),    32'(e_wait));
      chk("rnd exu_rs1_gnt", 32'(exu_rs1_gnt), 32'(e_gnt));
      chk("rnd rf_rs1_sel",  32'(rf_rs1_sel),  32'(e_sel));
      chk("rnd rf_rs1_idx",  32'(rf_rs1_idx),  32'(e_idx));
      chk("rnd op1", prdt_pc_add_op1, e_op1);
      chk("rnd op2", prdt_pc_add_op2, e_op2);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ifu_bpu_jalr_seq.md
# ifu_bpu_jalr_seq

Sequencer for jalr target resolution in the IFU lite branch predictor. It classifies each decoded jalr by rs1 index (x0 / x1 / xN), holds the fetch with `bpu_wait` while a register dependency is outstanding, and arbitrates regfile read port 1 between the EXU (default owner) and the BPU. Once resolved, it presents the adder operands `rs1 + imm` to the next-PC adder with a one-cycle `prdt_valid` pulse.

## Interface
- `X_LEN`, 32, data width
- `RFIDX_WIDTH`, 5, register index width
- `STARVE_MAX`, 4, consecutive denied BPU read cycles before the BPU is forced onto the port (1..7)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `jalr_req_valid`  in  1  decoded jalr present; IFU holds it and all request fields stable while `bpu_wait`=1
- `jalr_rs1idx`  in  RFIDX_WIDTH  jalr rs1 index
- `jalr_imm`  in  X_LEN  jalr immediate, already sign-extended
- `flush`  in  1  pipeline flush; cancels any jalr in flight
- `oitf_empty`  in  1  no long-latency ops outstanding
- `ir_valid`  in  1  IR holds an instruction
- `ir_rdwen`  in  1  IR instruction writes rd
- `ir_rdidx`  in  RFIDX_WIDTH  IR rd index
- `exu_rs1_req`  in  1  EXU needs read port 1 this cycle
- `exu_rs1_gnt`  out  1  EXU owns port 1 this cycle
- `rf_rs1_sel`  out  1  1 = BPU drives port 1 index
- `rf_rs1_idx`  out  RFIDX_WIDTH  BPU read index; equals latched rs1 when `rf_rs1_sel`=1, else 0
- `rf2bpu_x1`  in  X_LEN  dedicated x1 read value, combinational
- `rf2bpu_rs1`  in  X_LEN  port 1 read data, valid the cycle after the index is driven
- `bpu_wait`  out  1  stall fetch
- `prdt_valid`  out  1  operands valid this cycle (single-cycle pulse)
- `prdt_pc_add_op1`  out  X_LEN  rs1 value
- `prdt_pc_add_op2`  out  X_LEN  immediate

## Operation
- Derived signals: `x1_dep` = ~oitf_empty | (ir_valid & ir_rdwen & ir_rdidx==1); `xn_dep` = ~oitf_empty | ir_valid.
- States: IDLE, WAIT_X1, WAIT_XN, RD_REQ, RD_DATA.
- IDLE, `jalr_req_valid`=1 and `flush`=0:
  - rs1 = x0: `prdt_valid`=1 same cycle, op1=0, stay IDLE.
  - rs1 = x1 with `x1_dep`=0: `prdt_valid`=1 same cycle, op1=`rf2bpu_x1`.
  - rs1 = x1 with `x1_dep`=1: go to WAIT_X1.
  - rs1 = xN: go to WAIT_XN if `xn_dep`, else RD_REQ.
  - On entering any non-IDLE state, latch rs1idx and imm.
- WAIT_X1: when `x1_dep`=0, `prdt_valid`=1 with op1=`rf2bpu_x1`, then go to IDLE.
- WAIT_XN: when `xn_dep`=0, go to RD_REQ.
- RD_REQ, arbitration:
  - Grant BPU if `exu_rs1_req`=0 or `starve_cnt`==STARVE_MAX.
  - On grant: `rf_rs1_sel`=1, `exu_rs1_gnt`=0, clear `starve_cnt`, go to RD_DATA.
  - On denial: `exu_rs1_gnt`=1 and `starve_cnt`+1, saturating at STARVE_MAX.
- RD_DATA: capture `rf2bpu_rs1` into op1, `prdt_valid`=1, go to IDLE.
- `exu_rs1_gnt` = `exu_rs1_req` & ~`rf_rs1_sel` in every state.
- op2 = `jalr_imm` in IDLE, latched imm otherwise. Outputs hold their last value when `prdt_valid`=0.
- `bpu_wait`:
  - 1 in every non-IDLE state, except the cycle `prdt_valid` fires.
  - 1 in IDLE when the request leaves IDLE.
  - Otherwise 0.
- Cancel: `flush`=1, or `jalr_req_valid` dropping in a non-IDLE state → go to IDLE next cycle. No `prdt_valid` that cycle, `starve_cnt` cleared, and no port grant that cycle (`rf_rs1_sel`=0).

## Timing
- Reset state: IDLE, `starve_cnt`=0, latched rs1idx/imm/op1 = 0. Outputs at reset: `prdt_valid`=0, `bpu_wait`=0, `rf_rs1_sel`=0, `rf_rs1_idx`=0, op1=op2=0 (given `jalr_req_valid`=0).
- Latency from request to `prdt_valid`:
  - x0, or x1 without dependency: 0 cycles.
  - x1 with dependency: dependency-clear cycle.
  - xN without dependency or contention: 2 cycles (RD_REQ, RD_DATA).
  - Worst case under EXU contention: dependency wait + STARVE_MAX + 2.
- `flush` takes priority over every transition and every `prdt_valid` path, including the same-cycle IDLE paths.
- A new request is accepted in the IDLE cycle immediately after `prdt_valid`.
- `rst` asserted mid-sequence forces IDLE asynchronously. Any read in flight is discarded.

## Test plan
- rs1=x0, imm=0x10 in IDLE → same-cycle `prdt_valid`=1, op1=0, op2=0x10, `bpu_wait`=0.
- rs1=x1, `ir_rdidx`=1 with `ir_rdwen`=1 for 3 cycles, `rf2bpu_x1`=0x8000 → `bpu_wait`=1 for 3 cycles, then `prdt_valid` with op1=0x8000.
- rs1=x5, deps clear, `exu_rs1_req`=0, `rf2bpu_rs1`=0x1234 in the cycle after the grant → `rf_rs1_idx`=5 for one cycle, `prdt_valid` 2 cycles after the request, op1=0x1234.
- rs1=x5, `exu_rs1_req` held at 1 → `exu_rs1_gnt`=1 for 4 cycles, BPU granted on the 5th, `exu_rs1_gnt`=0 that cycle.
- `flush` in RD_DATA → no `prdt_valid`, IDLE next cycle, `bpu_wait`=0 once the request is removed.
- `rst` pulse while in WAIT_XN → all outputs at reset values, next x0 request completes normally.
